// File: rtl/bitstream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bitstream_decoder
// Summary  : Counts the ones in a unipolar stochastic bitstream over a window
//            of 2**WINDOW_LOG2 samples. The result is presented on valid/ready.
//            Optional macro BITSTREAM_DECODER_CONTINUOUS_EN re-arms windows
//            back to back after each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bitstream_decoder #(
    parameter int unsigned WINDOW_LOG2 = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        x,
    input  logic        start,
    input  logic        ready,
    output logic [31:0] y,
    output logic        valid,
    output logic        busy
);

    localparam int unsigned CW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] c_last_sample = CW'((1 << WINDOW_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   ones_q, ones_d;
    logic [31:0]     y_q, y_d;
    logic [CW-1:0]   w_ones_sum;

    assign w_ones_sum = ones_q + {{(CW-1){1'b0}}, x};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        y_d     = y_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                    ones_d  = '0;
                end
            end
            S_COUNT: begin
                cnt_d  = cnt_q + 1'b1;
                ones_d = w_ones_sum;
                if (cnt_q == c_last_sample) begin
                    y_d     = {{(32-CW){1'b0}}, w_ones_sum};
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Samples arriving here are dropped; counters restart on exit.
                if (ready) begin
                    cnt_d  = '0;
                    ones_d = '0;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
                    state_d = S_COUNT;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flags decode straight from the state register, so no input reaches them.
    assign y     = y_q;
    assign valid = (state_q == S_HOLD);
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bitstream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitstream_decoder
// Summary  : Scoreboard bench for bitstream_decoder with WINDOW_LOG2 = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitstream_decoder;

    localparam int unsigned WINDOW_LOG2 = 4;
    localparam int          N           = 1 << WINDOW_LOG2;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
    localparam logic        c_cont      = 1'b1;
`else
    localparam logic        c_cont      = 1'b0;
`endif

    logic        clk;
    logic        n_rst;
    logic        x;
    logic        start;
    logic        ready;
    logic [31:0] y;
    logic        valid;
    logic        busy;

    int          n_tests;
    int          n_fail;
    logic [31:0] sb_q[$];

    bitstream_decoder #(.WINDOW_LOG2(WINDOW_LOG2)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .x     (x),
        .start (start),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // A result is consumed once, at the edge where valid and ready meet.
    always @(negedge clk) begin
        if (n_rst && valid && ready) begin
            if (sb_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
            else                  check("sb_y", y, sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep();
        // Continuous mode never returns to IDLE, so restart from reset.
        if (c_cont) begin
            n_rst = 1'b0;
            #2;
            n_rst = 1'b1;
            tick();
        end
    endtask

    task automatic do_window(input logic [15:0] pat, input logic rdy, input int start_at);
        logic [31:0] exp;
        prep();
        ready = rdy;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp   = 0;
        for (int i = 0; i < N; i++) begin
            x     = pat[i];
            start = (i == start_at);
            exp   = exp + 32'(pat[i]);
            if (i == N - 1) check("valid_early", 32'(valid), 32'd0);
            tick();
        end
        start = 1'b0;
        x     = 1'b0;
        sb_q.push_back(exp);
        check("valid_at_EN", 32'(valid), 32'd1);
        check("busy_at_EN", 32'(busy), 32'd1);
        if (rdy) begin
            tick();
            check("valid_after_hs", 32'(valid), 32'd0);
            check("busy_after_hs", 32'(busy), 32'(c_cont));
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_rst   = 1'b0;
        x       = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        #12;
        check("rst_y", y, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        n_rst = 1'b1;
        tick();

        do_window(16'hFFFF, 1'b1, -1);
        do_window(16'h0000, 1'b1, -1);
        do_window(16'h5555, 1'b1, -1);
        do_window(16'h3C96, 1'b1, -1);

        // Hold: ready low, x and start toggling, result must not move.
        do_window(16'h5555, 1'b0, -1);
        for (int k = 0; k < 5; k++) begin
            x     = ~x;
            start = ~start;
            tick();
            check("hold_valid", 32'(valid), 32'd1);
            check("hold_y", y, 32'd8);
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        check("hold_release", 32'(valid), 32'd0);

        // Reset mid-window discards the partial count.
        prep();
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        x     = 1'b1;
        repeat (7) tick();
        n_rst = 1'b0;
        #1;
        check("midrst_y", y, 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        #2;
        n_rst = 1'b1;
        tick();
        do_window(16'hFFFF, 1'b1, -1);

        // Start pulse during COUNT is ignored.
        do_window(16'hA5F0, 1'b1, 3);

        // Continuous mode: second window needs no start.
        prep();
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        x     = 1'b1;
        repeat (N) tick();
        x = 1'b0;
        sb_q.push_back(32'd16);
        check("cont_w1_valid", 32'(valid), 32'd1);
        tick();
        check("cont_busy", 32'(busy), 32'(c_cont));
        repeat (N) tick();
        if (c_cont) sb_q.push_back(32'd0);
        check("cont_w2_valid", 32'(valid), 32'(c_cont));
        tick();
        ready = 1'b0;
        repeat (3) tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/bitstream_decoder.md
# bitstream_decoder

Converts a unipolar stochastic bitstream, such as a neuron output, back into a binary count by accumulating ones over a fixed window of 2**WINDOW_LOG2 clock cycles. It sits at the output boundary of the bitstream network and is the inverse of the value-to-bitstream generator. Results are presented on a valid/ready handshake so a downstream consumer (readout, scoreboard, next-layer loader) can take them at its own pace.

## Interface
- WINDOW_LOG2, default 8: window length N = 2**WINDOW_LOG2 samples; internal counter is WINDOW_LOG2+1 bits wide.
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- x  input  1  bitstream sample.
- start  input  1  request a new window; sampled only in IDLE.
- ready  input  1  consumer accepts y when valid is high.
- y  output  int  count of ones in the last window, 0..N, zero-extended.
- valid  output  1  y holds a completed result.
- busy  output  1  high in COUNT and HOLD.

## Operation
- FSM states: IDLE, COUNT, HOLD.
- IDLE: valid=0, busy=0. If start=1 at an edge, go to COUNT, clear the sample counter and the ones counter. The start cycle does not sample x.
- COUNT: on each edge, add x to the ones counter and increment the sample counter. After the Nth sample, load y with the count including that sample, set valid=1, and go to HOLD.
- HOLD: valid=1, y stable, x ignored. When valid and ready are both high at an edge, clear valid and leave HOLD. The next state depends on the configuration.
- start is ignored outside IDLE. ready is ignored when valid=0.
- y keeps its last value after the handshake and changes only when a new window completes.
- Arithmetic: the ones counter never exceeds N, so there is no overflow and no saturation logic. y[31:WINDOW_LOG2+1] is always 0.
- Reset: asserting n_rst at any time, including mid-window or mid-HOLD, forces IDLE, y=0, valid=0, busy=0, and clears both counters. A partial count is discarded.

## Timing
- Reset values: y=0, valid=0, busy=0, state IDLE.
- Let E0 be the edge at which start is sampled in IDLE.
  - x is sampled at edges E1..EN.
  - valid and y update at EN, so they are visible in the cycle after EN.
  - busy rises at E0.
- Start-to-valid latency is N edges.
- The handshake completes at the first edge with valid=1 and ready=1. valid is low after that edge.
- There is no combinational path from any input to any output. All outputs are registered.
- Minimum period between results is N+2 edges without continuous mode and N+1 edges with it.

## Configuration
- BITSTREAM_DECODER_CONTINUOUS_EN defined:
  - The handshake edge in HOLD goes directly to COUNT with cleared counters.
  - The next window samples x from the following edge on, with no start needed.
  - IDLE is entered only after reset; the first window still requires start.
  - busy stays high continuously after the first start.
- Macro undefined: the handshake edge returns to IDLE, and every window requires a new start.
- In both modes, samples arriving during HOLD are dropped and never counted.

## Test plan
- WINDOW_LOG2=4, start pulse, x=1 for 16 cycles, ready=1 -> valid visible after E16 with y=16; valid=0 after the next edge; busy=0 (macro off).
- Same setup with x=0 throughout -> y=0, valid after E16. Then x alternating 1,0 from E1 -> y=8.
- Complete a window with y=8, hold ready=0 for 5 cycles while toggling x and pulsing start -> y stays 8 and valid stays 1 throughout; raising ready clears valid at that edge.
- Assert n_rst after sample 7 of a window of all ones -> y=0, valid=0, busy=0 immediately. A new start with x=1 then gives y=16, not 23.
- Pulse start while in COUNT at sample 3 -> ignored; the result still arrives at E16 relative to the original start.
- With BITSTREAM_DECODER_CONTINUOUS_EN: one start, ready=1, x=1 for window 1 then x=0 -> y=16 then y=0 with no second start. With the macro off, the same stimulus produces only the first result.
